// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between instruction fetch and
// load/store, with in-order routing of responses back to the issuer.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    resp_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    owner_t           owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             lock;
    owner_t           lock_owner;
    owner_t           last_grant;
    logic             resp_err;

    owner_t sel;
    owner_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   issue;
    logic   grant;
    logic   pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (MAX_OUTSTANDING == 1) begin
            return '0;
        end
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A locked owner keeps the port until granted; ties go to whoever lost last.
    always_comb begin
        sel = OWN_INSTR;
        if (lock) begin
            sel = lock_owner;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_grant == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        end else if (data_req_i) begin
            sel = OWN_DATA;
        end
    end

    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = owner_q[rd_ptr];

    assign issue = (instr_req_i | data_req_i | lock) & ~fifo_full;
    assign grant = issue & mem_gnt_i;
    assign pop   = mem_rvalid_i & ~fifo_empty;

    assign mem_req_o   = issue;
    assign mem_addr_o  = (sel == OWN_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = (sel == OWN_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == OWN_DATA) ? data_be_i    : '1;
    assign mem_wdata_o = (sel == OWN_DATA) ? data_wdata_i : '0;

    assign instr_gnt_o = grant & (sel == OWN_INSTR);
    assign data_gnt_o  = grant & (sel == OWN_DATA);

    assign instr_rvalid_o = pop & (head == OWN_INSTR);
    assign data_rvalid_o  = pop & (head == OWN_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign resp_err_o = resp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock       <= 1'b0;
            lock_owner <= OWN_INSTR;
            last_grant <= OWN_INSTR;
            resp_err   <= 1'b0;
        end else begin
            if (grant) begin
                owner_q[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
                last_grant      <= sel;
                lock            <= 1'b0;
            end else if (issue) begin
                lock       <= 1'b1;
                lock_owner <= sel;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (mem_rvalid_i && fifo_empty) begin
                resp_err <= 1'b1;
            end
            case ({grant, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one instruction/data memory port between the core's instruction-fetch interface and its data (load/store) interface.
- Sits between the core and the unified memory.
- Arbitrates requests round-robin, holds the chosen request stable until the memory grants it, and tracks outstanding transactions in order so each rvalid/rdata returns to the interface that issued it.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (owner FIFO depth, power of 2, >=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch response data.
- data_req_i  in  1  load/store request.
- data_addr_i  in  ADDR_WIDTH  load/store address.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store accepted this cycle.
- data_rvalid_o  out  1  load/store response valid (loads and stores).
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response valid (one per granted request, in order).
- mem_rdata_i  in  DATA_WIDTH  memory response data.
- resp_err_o  out  1  sticky: rvalid received with no outstanding transaction.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Owner FIFO empty; lock cleared; last_grant=INSTR, so data wins the first tie; resp_err_o=0.
  - All outputs are combinational from this state. With no requests, mem_req_o, both gnt and both rvalid outputs are 0.
  - Reset mid-transaction discards outstanding owners. Any later mem_rvalid_i with an empty FIFO sets resp_err_o.
- Arbitration (combinational, cycle N):
  - If lock is set, sel = locked owner.
  - Else if exactly one requester is active, sel = that requester.
  - Else if both are active, sel = the one not equal to last_grant.
- Issue:
  - mem_req_o = (instr_req_i | data_req_i | lock) & !fifo_full.
  - Address, we, be and wdata are muxed from sel. Instruction requests drive we=0, be=all ones, wdata=0.
  - sel_gnt_o = mem_gnt_i & mem_req_o; the non-selected gnt is 0.
  - Grant latency is zero cycles: gnt is combinational with mem_gnt_i.
- Lock:
  - When mem_req_o=1 and mem_gnt_i=0, lock<=1 and owner<=sel, so the selection is frozen until granted.
  - The locked requester must hold its req and fields stable (OBI rule). The arbiter does not re-check them.
  - Lock clears on the grant cycle.
- On grant: push sel into the owner FIFO and set last_grant<=sel. Back-to-back grants every cycle are allowed.
- FIFO full: when count==MAX_OUTSTANDING, mem_req_o=0 and no gnt is issued. A requester already locked stays locked.
- Response:
  - When mem_rvalid_i=1, the FIFO head is popped and routed. Target rvalid_o=1 and target rdata_o=mem_rdata_i, same cycle with no added latency.
  - Non-target rvalid is 0.
  - Both rdata outputs are driven with mem_rdata_i at all times; only the rvalid outputs are gated.
- Simultaneous push and pop: count is unchanged, and a pop from full frees a slot only in the next cycle.
  - Full detection uses the registered count.
- Response with empty FIFO: ignored (no rvalid out) and resp_err_o<=1; stays 1 until reset.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.

Test Plan:
- Reset, then instr_req only at addr 0x00, mem_gnt=1, rvalid next cycle with 0x00000433 -> instr_gnt=1 at cycle 0; instr_rvalid=1 and instr_rdata=0x00000433 at cycle 1; data_rvalid=0.
- Both req continuously, mem_gnt=1 every cycle, first grant after reset -> grants alternate data, instr, data, instr. Responses are routed in the same order.
- Both req, mem_gnt=0 for 3 cycles then 1; data store addr 0x40, be=4'b0011, wdata=0xDEADBEEF -> mem_addr stays 0x40 and mem_we stays 1 for all 4 cycles. data_gnt pulses only on cycle 4; instr_gnt=0 throughout.
- MAX_OUTSTANDING=2, three grants with no rvalid -> third cycle mem_req_o=0 and no gnt. Then rvalid in cycle k -> mem_req_o=1 again at k+1.
- Grant and rvalid in the same cycle with FIFO at count 1 -> count stays 1. The response goes to the older owner and the new owner is queued.
- mem_rvalid_i=1 with empty FIFO -> no rvalid out and resp_err_o=1 next cycle. Assert rst_n=0 for one cycle -> resp_err_o=0.
